// File: rtl/softmax_stream_driver.sv
// Host-to-softmax stream driver: programs the INT-to-FP LUT from host words,
// streams one row of int8 scores into the engine and forwards its results.
module softmax_stream_driver #(
  parameter int SOFTMAX_NUM = 64,
  parameter int IDATA_BIT   = 8,
  parameter int LUT_DATA    = 16,
  parameter int LUT_ADDR    = 4,
  parameter int LUT_DEPTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 load_lut,
  input  logic [7:0]           cfg_shift_in,
  input  logic                 host_valid,
  input  logic [LUT_DATA-1:0]  host_data,
  output logic                 host_ready,
  output logic [7:0]           cfg_consmax_shift,
  output logic [LUT_ADDR-1:0]  lut_waddr,
  output logic                 lut_wen,
  output logic [LUT_DATA-1:0]  lut_wdata,
  output logic [IDATA_BIT-1:0] idata,
  output logic                 idata_valid,
  input  logic [IDATA_BIT-1:0] odata,
  input  logic                 odata_valid,
  output logic [IDATA_BIT-1:0] res_data,
  output logic                 res_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 err_unexp
);

  localparam int SW = $clog2(SOFTMAX_NUM + 1);
  localparam int WW = $clog2(LUT_DEPTH + 1);
  localparam logic [SW-1:0] S_FULL = SW'(SOFTMAX_NUM);
  localparam logic [SW-1:0] S_LAST = SW'(SOFTMAX_NUM - 1);
  localparam logic [WW-1:0] W_LAST = WW'(LUT_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_LUT = 2'd1,
    STREAM   = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] scnt, rcnt;
  logic [WW-1:0] wcnt;
  logic          accept, rcnt_full, res_count, res_unexp, finish;

  assign host_ready = (state == LOAD_LUT) || ((state == STREAM) && (scnt < S_FULL));
  assign accept     = host_valid && host_ready;
  assign rcnt_full  = (rcnt == S_FULL);
  // A result beyond the row length, or with no row open, is forwarded but not counted.
  assign res_count  = odata_valid && (state != IDLE) && !rcnt_full;
  assign res_unexp  = odata_valid && ((state == IDLE) || rcnt_full);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
    case (state)
      IDLE:     if (start) state_nxt = load_lut ? LOAD_LUT : STREAM;
      LOAD_LUT: if (accept && (wcnt == W_LAST)) state_nxt = STREAM;
      STREAM:   if (accept && (scnt == S_LAST)) state_nxt = DRAIN;
      DRAIN: begin
        // Either the row already completed during STREAM, or this result completes it.
        if (rcnt_full || (odata_valid && (rcnt == S_LAST))) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Registered output stage: every strobe lands one cycle after its accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_consmax_shift <= '0;
      wcnt              <= '0;
      scnt              <= '0;
      rcnt              <= '0;
      lut_wen           <= 1'b0;
      lut_waddr         <= '0;
      lut_wdata         <= '0;
      idata_valid       <= 1'b0;
      idata             <= '0;
      res_valid         <= 1'b0;
      res_data          <= '0;
      done              <= 1'b0;
      err_unexp         <= 1'b0;
    end else begin
      done        <= finish;
      lut_wen     <= 1'b0;
      idata_valid <= 1'b0;
      res_valid   <= odata_valid;
      if ((state == IDLE) && start) begin
        cfg_consmax_shift <= cfg_shift_in;
        wcnt              <= '0;
        scnt              <= '0;
        rcnt              <= '0;
      end
      if (accept && (state == LOAD_LUT)) begin
        lut_wen   <= 1'b1;
        lut_waddr <= wcnt[LUT_ADDR-1:0];
        lut_wdata <= host_data;
        wcnt      <= wcnt + WW'(1);
      end
      if (accept && (state == STREAM)) begin
        idata_valid <= 1'b1;
        idata       <= host_data[IDATA_BIT-1:0];
        scnt        <= scnt + SW'(1);
      end
      if (odata_valid) res_data <= odata;
      if (res_count)   rcnt <= rcnt + SW'(1);
      if (res_unexp)   err_unexp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_softmax_stream_driver.sv
// Directed bench for softmax_stream_driver: row table plus hand sequences for
// unexpected results and mid-row reset; includes a small softmax echo model.
module tb_softmax_stream_driver;
  localparam int N  = 64;
  localparam int LD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0, load_lut = 1'b0;
  logic [7:0]  cfg_shift_in = 8'h00;
  logic        host_valid = 1'b0;
  logic [15:0] host_data = 16'h0000;
  logic        host_ready;
  logic [7:0]  cfg_consmax_shift;
  logic [3:0]  lut_waddr;
  logic        lut_wen;
  logic [15:0] lut_wdata;
  logic [7:0]  idata;
  logic        idata_valid;
  logic [7:0]  odata = 8'h00;
  logic        odata_valid = 1'b0;
  logic [7:0]  res_data;
  logic        res_valid, busy, done, err_unexp;

  softmax_stream_driver #(.SOFTMAX_NUM(N), .IDATA_BIT(8), .LUT_DATA(16), .LUT_ADDR(4), .LUT_DEPTH(LD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_lut(load_lut), .cfg_shift_in(cfg_shift_in),
    .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
    .cfg_consmax_shift(cfg_consmax_shift), .lut_waddr(lut_waddr), .lut_wen(lut_wen),
    .lut_wdata(lut_wdata), .idata(idata), .idata_valid(idata_valid), .odata(odata),
    .odata_valid(odata_valid), .res_data(res_data), .res_valid(res_valid), .busy(busy),
    .done(done), .err_unexp(err_unexp));

  always #5 clk = ~clk;

  typedef enum int {M_IDLE, M_LOAD, M_STREAM, M_DRAIN} mph_t;
  typedef struct {
    logic       load;
    logic [7:0] shift;
    int         gap;
    bit         dup;
    bit         follow;
    int         exp_lut;
    int         exp_res;
    logic       exp_err;
  } row_t;

  row_t        rows[5];
  int          n_cmp = 0, n_fail = 0;
  mph_t        m_phase = M_IDLE;
  int          m_w, m_s;
  logic [15:0] q[$];
  logic        exp_lut_v = 1'b0, exp_id_v = 1'b0, exp_res_v = 1'b0;
  logic [3:0]  exp_lut_a;
  logic [15:0] exp_lut_d;
  logic [7:0]  exp_id_d, exp_res_d;
  logic        pv[3];
  logic [7:0]  pd[3];
  int          row_lut, row_id, row_res, row_done, row_cyc, done_total = 0;
  int          gap = 0, dup_at = -1;
  bit          mdl_en = 1'b1, follow = 1'b0, extra_done = 1'b0, inj_next = 1'b0;
  logic [7:0]  inj_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_lut_wen"}, lut_wen, 0);
    chk({tag, "_lut_waddr"}, lut_waddr, 0);
    chk({tag, "_lut_wdata"}, lut_wdata, 0);
    chk({tag, "_idata_valid"}, idata_valid, 0);
    chk({tag, "_idata"}, idata, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err_unexp, 0);
    chk({tag, "_cfg"}, cfg_consmax_shift, 0);
    chk({tag, "_host_ready"}, host_ready, 0);
  endtask

  // One clock: check last cycle's predicted strobes, run the softmax model, drive inputs.
  task automatic cyc();
    logic        mv, acc, fo, mdl_ready;
    logic [7:0]  md;
    logic [15:0] w;
    mph_t        ph0;
    @(negedge clk);
    if (exp_lut_v || lut_wen) begin
      chk("lut_wen", lut_wen, exp_lut_v);
      if (exp_lut_v) begin
        chk("lut_waddr", lut_waddr, exp_lut_a);
        chk("lut_wdata", lut_wdata, exp_lut_d);
      end
    end
    if (lut_wen) row_lut++;
    if (exp_id_v || idata_valid) begin
      chk("idata_valid", idata_valid, exp_id_v);
      if (exp_id_v) chk("idata", idata, exp_id_d);
    end
    if (idata_valid) row_id++;
    if (exp_res_v || res_valid) begin
      chk("res_valid", res_valid, exp_res_v);
      if (exp_res_v) chk("res_data", res_data, exp_res_d);
      if (res_valid && mdl_en && !inj_next && row_res < N) chk("res_value_i", res_data, row_res);
    end
    if (res_valid) row_res++;
    if (done) begin
      row_done++;
      done_total++;
      chk("done_with_last_res", res_valid, 1);
      m_phase = M_IDLE;
    end
    mdl_ready = (m_phase == M_LOAD) || ((m_phase == M_STREAM) && (m_s < N));
    chk("host_ready", host_ready, mdl_ready);

    mv = pv[2]; md = pd[2];
    pv[2] = pv[1]; pd[2] = pd[1];
    pv[1] = pv[0]; pd[1] = pd[0];
    pv[0] = idata_valid && mdl_en; pd[0] = idata;

    start = 1'b0;
    if (row_cyc == dup_at) begin
      start = 1'b1; load_lut = 1'b1; cfg_shift_in = 8'h99;
    end
    host_valid = (q.size() > 0) && ($urandom_range(99) >= gap);
    host_data  = host_valid ? q[0] : 16'hDEAD;
    acc = host_valid && host_ready;
    ph0 = m_phase;
    exp_lut_v = 1'b0; exp_id_v = 1'b0;
    if (acc) begin
      w = q.pop_front();
      if (m_phase == M_LOAD) begin
        exp_lut_v = 1'b1; exp_lut_a = m_w[3:0]; exp_lut_d = w;
        m_w++;
        if (m_w == LD) m_phase = M_STREAM;
      end else begin
        exp_id_v = 1'b1; exp_id_d = w[7:0];
        m_s++;
        if (m_s == N) m_phase = M_DRAIN;
      end
    end
    fo = 1'b0;
    odata = md;
    if (follow && exp_id_v) begin
      fo = 1'b1; odata = exp_id_d;
    end else if (follow && ph0 == M_DRAIN && !extra_done) begin
      fo = 1'b1; odata = 8'hEE; extra_done = 1'b1;
    end
    if (inj_next) odata = inj_data;
    odata_valid = mv || fo || inj_next;
    exp_res_v = odata_valid;
    exp_res_d = odata;
    row_cyc++;
  endtask

  task automatic begin_row(input row_t r);
    row_lut = 0; row_id = 0; row_res = 0; row_done = 0; row_cyc = 0;
    m_w = 0; m_s = 0; extra_done = 1'b0;
    follow = r.follow; mdl_en = !r.follow; gap = r.gap; dup_at = r.dup ? 10 : -1;
    q.delete();
    if (r.load) for (int k = 0; k < LD; k++) q.push_back(16'h3F80 + 16'(k));
    for (int i = 0; i < N; i++) q.push_back({8'(i * 3 + 1), 8'(i)});
    start = 1'b1; load_lut = r.load; cfg_shift_in = r.shift; host_valid = 1'b0;
    m_phase = r.load ? M_LOAD : M_STREAM;
    cyc();
    chk("cfg_shift_latched", cfg_consmax_shift, r.shift);
    chk("busy_in_row", busy, 1);
  endtask

  task automatic run_row(input row_t r);
    begin_row(r);
    for (int c = 0; c < 3000 && row_done == 0; c++) cyc();
    chk("row_done_seen", row_done, 1);
    chk("busy_after_done", busy, 0);
    repeat (3) cyc();
    chk("row_lut_writes", row_lut, r.exp_lut);
    chk("row_scores", row_id, N);
    chk("row_results", row_res, r.exp_res);
    chk("row_done_count", row_done, 1);
    chk("row_cfg_kept", cfg_consmax_shift, r.shift);
    chk("row_err", err_unexp, r.exp_err);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin pv[i] = 1'b0; pd[i] = 8'h00; end
    rows[0] = '{1'b1, 8'h05, 0,  1'b0, 1'b0, LD, N,     1'b0};
    rows[1] = '{1'b0, 8'h1C, 0,  1'b0, 1'b0, 0,  N,     1'b0};
    rows[2] = '{1'b0, 8'hE3, 50, 1'b1, 1'b0, 0,  N,     1'b0};
    rows[3] = '{1'b1, 8'h7F, 30, 1'b1, 1'b0, LD, N,     1'b0};
    rows[4] = '{1'b0, 8'h42, 0,  1'b0, 1'b1, 0,  N + 1, 1'b1};

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    for (int r = 0; r < 5; r++) run_row(rows[r]);

    // Reset asserted mid-row, between clock edges.
    begin_row(rows[1]);
    for (int c = 0; c < 500 && row_id < 20; c++) cyc();
    chk("partial_scores", row_id, 20);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrow_reset");
    q.delete();
    for (int i = 0; i < 3; i++) pv[i] = 1'b0;
    exp_lut_v = 1'b0; exp_id_v = 1'b0; exp_res_v = 1'b0;
    host_valid = 1'b0; odata_valid = 1'b0; start = 1'b0;
    m_phase = M_IDLE;
    @(negedge clk);
    rst_n = 1'b1;
    run_row(rows[1]);

    // Result with no row open.
    begin
      int d0;
      d0 = done_total;
      inj_data = 8'h77; inj_next = 1'b1;
      cyc();
      inj_next = 1'b0;
      cyc();
      chk("idle_result_err", err_unexp, 1);
      repeat (4) cyc();
      chk("err_sticky", err_unexp, 1);
      chk("idle_result_no_done", done_total, d0);
      chk("idle_busy", busy, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/softmax_stream_driver.md
Name: softmax_stream_driver

Overview:
- Initiator-side driver for the softmax vector engine's LUT-write and score-stream interface.
- Takes words from a host valid/ready stream and uses them to program the softmax INT-to-FP LUT, then streams one row of SOFTMAX_NUM int8 scores into idata/idata_valid.
- Collects the SOFTMAX_NUM odata results and forwards them to the host.
- Sits between the global-bus host port and the softmax instance; one row per start.

Parameters:
SOFTMAX_NUM, 64, scores per row (context length); >=2
IDATA_BIT, 8, score and result width
LUT_DATA, 16, LUT entry width (1 sign + 8 exp + 7 mantissa)
LUT_ADDR, 4, LUT address width (IDATA_BIT>>1)
LUT_DEPTH, 16, LUT entries (2**LUT_ADDR)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin one row; sampled only in IDLE
load_lut  in  1  sampled with start; 1 = program LUT before streaming
cfg_shift_in  in  8  shift value, latched at start
host_valid  in  1  host word valid
host_data  in  LUT_DATA  host word; LUT entry, or score in [IDATA_BIT-1:0]
host_ready  out  1  driver accepts host word
cfg_consmax_shift  out  8  registered shift to softmax
lut_waddr  out  LUT_ADDR  LUT write address
lut_wen  out  1  LUT write strobe
lut_wdata  out  LUT_DATA  LUT write data
idata  out  IDATA_BIT  score to softmax
idata_valid  out  1  score strobe
odata  in  IDATA_BIT  softmax result
odata_valid  in  1  result strobe
res_data  out  IDATA_BIT  forwarded result
res_valid  out  1  forwarded result strobe
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, row complete
err_unexp  out  1  sticky; odata_valid seen in IDLE, or more than SOFTMAX_NUM results in a row

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0 (including cfg_consmax_shift and err_unexp); all counters 0.
- Clear of err_unexp: reset only.
- Handshake: a host word is accepted on a clock edge with host_valid && host_ready. host_ready is a registered-state decode, not combinational on host_valid.
- IDLE:
  - host_ready=0.
  - start=1 latches cfg_shift_in into cfg_consmax_shift (visible next cycle) and clears wcnt, scnt and rcnt.
  - Next state is LOAD_LUT if load_lut=1, else STREAM.
- LOAD_LUT:
  - host_ready=1.
  - Accepted word k drives, on the following cycle, lut_wen=1, lut_waddr=k, lut_wdata=host_data. Latency is 1 cycle; back-to-back accepts give consecutive write cycles.
  - After accepting word LUT_DEPTH-1, move to STREAM. The final write strobe overlaps the first STREAM cycle.
  - lut_wen=0 in every cycle without a pending write.
- STREAM:
  - host_ready=1 while scnt<SOFTMAX_NUM.
  - Accepted word drives, next cycle, idata=host_data[IDATA_BIT-1:0] and idata_valid=1. Upper bits are ignored.
  - After accept number SOFTMAX_NUM, move to DRAIN with host_ready=0.
  - idata_valid is a single-cycle pulse per accepted word. idata holds its last value otherwise.
- DRAIN: host_ready=0; wait for the result count.
- Result path (STREAM or DRAIN): each odata_valid gives res_data=odata and res_valid=1 on the next cycle, and increments rcnt. Results arriving during STREAM are valid and counted.
- Completion:
  - When rcnt reaches SOFTMAX_NUM and the state is DRAIN, pulse done for 1 cycle (aligned with the last res_valid) and return to IDLE.
  - If the final result arrives in the same cycle the last score is accepted, done fires after the transition to DRAIN; no result is lost.
- Unexpected results: an odata_valid in IDLE, or after rcnt=SOFTMAX_NUM, sets err_unexp. That result is still forwarded on res_valid but is not counted.
- Counter widths: $clog2(SOFTMAX_NUM+1), $clog2(LUT_DEPTH+1). Counters saturate and never wrap within a row.
- start while busy=1 is ignored (no latch, no restart).
- Host stalls (host_valid=0) in any state only pause the counters. There is no timeout.
- Reset mid-row aborts immediately: outputs go to 0, state=IDLE, and any partially written LUT is left as-is in the softmax.

Test Plan:
1. Reset, then start with load_lut=1, cfg_shift_in=8'h05, and 16 LUT words 16'h3F80+k -> cfg_consmax_shift=5; lut_wen pulses with lut_waddr 0..15 and data 3F80..3F8F, each 1 cycle after accept; state then STREAM.
2. load_lut=0; stream 64 scores 0..63 with host_valid held high -> 64 consecutive idata_valid pulses with idata 0..63; host_ready drops after the 64th accept; no lut_wen.
3. Model softmax returning 64 odata (value i) starting 3 cycles after the first idata, interleaved with streaming -> 64 res_valid with res_data 0..63; done pulses once with the last res_valid; busy=0 next cycle.
4. Random host_valid gaps (about 50%) and a second start pulse mid-row -> idata order unchanged, second start ignored, exactly 64 idata_valid.
5. odata_valid in IDLE, and a 65th odata_valid in DRAIN -> err_unexp=1 and sticky; done count unchanged.
6. Assert rst_n=0 after 20 scores -> all outputs 0 asynchronously; after release, a fresh start streams a full 64-score row correctly.
